// File: rtl/msb_pkg.sv
// Shared types and default sizing for the multi-stream buffer host request controller.
package msb_pkg;
    localparam int NSTRMS_DEF  = 64;
    localparam int NCH_DEF     = 2;
    localparam int MAX_OUT_DEF = 4;
    localparam int SID_W_DEF   = $clog2(NSTRMS_DEF);

    typedef logic [SID_W_DEF-1:0] sid_t;

    typedef enum logic [1:0] {
        RST_IDLE  = 2'd0,
        RST_DRAIN = 2'd1,
        RST_DONE  = 2'd2
    } rst_state_e;
endpackage

// File: rtl/msb_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer; pointer moves
// to winner+1 only when the caller consumes the grant.
module msb_rr_arb #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] win_o,
    output logic          any_o
);
    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    logic [PW-1:0] win;

    always_comb begin
        found = 1'b0;
        win   = '0;
        // First pass covers [ptr, N), second pass wraps to the lowest requester.
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j >= int'(ptr_q))) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
        gnt_o = '0;
        for (int j = 0; j < N; j++) begin
            gnt_o[j] = found && (win == PW'(j));
        end
        any_o = found;
        win_o = win;
        ptr_d = (int'(win) == N - 1) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (adv_i && found) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/msb_host_req_ctrl.sv
// Multi-channel host request controller: per-stream refill tracking, response routing and
// drain-before-ack stream reset. Define MSB_HOST_REQ_PERF_EN to add perf counter ports.
module msb_host_req_ctrl
    import msb_pkg::*;
#(
    parameter int nstrms    = NSTRMS_DEF,
    parameter int sid_width = $clog2(nstrms),
    parameter int nch       = NCH_DEF,
    parameter int max_out   = MAX_OUT_DEF,
    parameter int cnt_width = $clog2(max_out + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [nstrms-1:0]          i_req_v,
    output logic [nstrms-1:0]          i_req_r,
    output logic [nch-1:0]             o_req_v,
    input  logic [nch-1:0]             o_req_r,
    output logic [nch*sid_width-1:0]   o_req_sid,
    input  logic [nch-1:0]             i_rsp_v,
    output logic [nch-1:0]             i_rsp_r,
    input  logic [nch*sid_width-1:0]   i_rsp_sid,
    output logic [nstrms-1:0]          o_rsp_v,
    input  logic [nstrms-1:0]          o_rsp_r,
    input  logic                       i_rst_v,
    output logic                       i_rst_r,
    input  logic [sid_width-1:0]       i_rst_sid,
    output logic                       o_err
`ifdef MSB_HOST_REQ_PERF_EN
    ,
    output logic [31:0]                o_perf_req,
    output logic [31:0]                o_perf_full
`endif
);
    localparam int CHW = (nch > 1) ? $clog2(nch) : 1;

    logic [nstrms-1:0][cnt_width-1:0] cnt_q, cnt_d;
    logic [nch-1:0]                   slot_v_q;
    logic [nch-1:0][sid_width-1:0]    slot_sid_q;
    logic                             rsp_v_q;
    logic [sid_width-1:0]             rsp_sid_q;
    logic                             err_q, err_d;
    rst_state_e                       state_q, state_d;
    logic [sid_width-1:0]             rst_sid_q, rst_sid_d;

    logic [nstrms-1:0]    elig, req_gnt;
    logic [sid_width-1:0] req_win;
    logic                 req_any, any_free, grant;
    logic [CHW-1:0]       sel_ch;
    logic [nch-1:0]       rsp_gnt;
    logic [CHW-1:0]       rsp_win;
    logic                 rsp_any, rsp_free, rsp_acc;
    logic [sid_width-1:0] rsp_sid_in;
    logic                 drained;

    // ---------------- request path ----------------
    always_comb begin
        elig = '0;
        for (int s = 0; s < nstrms; s++) begin
            elig[s] = i_req_v[s] && (cnt_q[s] < cnt_width'(max_out))
                   && !((state_q != RST_IDLE) && (rst_sid_q == sid_width'(s)));
        end
    end

    msb_rr_arb #(.N(nstrms)) u_req_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (elig),
        .adv_i (grant),
        .gnt_o (req_gnt),
        .win_o (req_win),
        .any_o (req_any)
    );

    // A slot that is handing off this cycle counts as free.
    always_comb begin
        any_free = 1'b0;
        sel_ch   = '0;
        for (int c = nch - 1; c >= 0; c--) begin
            if (!slot_v_q[c] || o_req_r[c]) begin
                any_free = 1'b1;
                sel_ch   = CHW'(c);
            end
        end
    end

    assign grant     = req_any && any_free;
    assign i_req_r   = grant ? req_gnt : '0;
    assign o_req_v   = slot_v_q;
    assign o_req_sid = slot_sid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v_q   <= '0;
            slot_sid_q <= '0;
        end else begin
            for (int c = 0; c < nch; c++) begin
                if (grant && (sel_ch == CHW'(c))) begin
                    slot_v_q[c]   <= 1'b1;
                    slot_sid_q[c] <= req_win;
                end else if (o_req_r[c]) begin
                    slot_v_q[c] <= 1'b0;
                end
            end
        end
    end

    // ---------------- response path ----------------
    msb_rr_arb #(.N(nch)) u_rsp_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (i_rsp_v),
        .adv_i (rsp_acc),
        .gnt_o (rsp_gnt),
        .win_o (rsp_win),
        .any_o (rsp_any)
    );

    assign rsp_sid_in = i_rsp_sid[int'(rsp_win)*sid_width +: sid_width];
    assign rsp_free   = !rsp_v_q || o_rsp_r[rsp_sid_q];
    assign rsp_acc    = rsp_any && rsp_free;
    assign i_rsp_r    = rsp_acc ? rsp_gnt : '0;

    always_comb begin
        o_rsp_v = '0;
        if (rsp_v_q) o_rsp_v[rsp_sid_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_v_q   <= 1'b0;
            rsp_sid_q <= '0;
        end else if (rsp_acc) begin
            rsp_v_q   <= 1'b1;
            rsp_sid_q <= rsp_sid_in;
        end else if (rsp_v_q && o_rsp_r[rsp_sid_q]) begin
            rsp_v_q   <= 1'b0;
        end
    end

    // ---------------- outstanding counters ----------------
    // A grant and a response for the same stream in one cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int s = 0; s < nstrms; s++) begin
            if (rsp_acc && (rsp_sid_in == sid_width'(s))) begin
                if (cnt_q[s] == '0) err_d = 1'b1;
                if (!req_gnt[s] || !grant) begin
                    if (cnt_q[s] != '0) cnt_d[s] = cnt_q[s] - 1'b1;
                end
            end else if (grant && req_gnt[s]) begin
                cnt_d[s] = cnt_q[s] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

    // ---------------- stream reset FSM ----------------
    always_comb begin
        drained = (cnt_q[rst_sid_q] == '0) && !(rsp_v_q && (rsp_sid_q == rst_sid_q));
        for (int c = 0; c < nch; c++) begin
            if (slot_v_q[c] && (slot_sid_q[c] == rst_sid_q)) drained = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_sid_d = rst_sid_q;
        i_rst_r   = 1'b0;
        case (state_q)
            RST_IDLE: begin
                if (i_rst_v) begin
                    state_d   = RST_DRAIN;
                    rst_sid_d = i_rst_sid;
                end
            end
            RST_DRAIN: if (drained) state_d = RST_DONE;
            RST_DONE: begin
                i_rst_r = 1'b1;
                state_d = RST_IDLE;
            end
            default: state_d = RST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_IDLE;
            rst_sid_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_sid_q <= rst_sid_d;
        end
    end

`ifdef MSB_HOST_REQ_PERF_EN
    logic [31:0] perf_req_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_req_q  <= '0;
            perf_full_q <= '0;
        end else begin
            if (grant) perf_req_q <= perf_req_q + 32'd1;
            if ((|i_req_v) && !any_free) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign o_perf_req  = perf_req_q;
    assign o_perf_full = perf_full_q;
`endif
endmodule

// File: tb/tb_msb_host_req_ctrl.sv
// Directed self-checking bench for msb_host_req_ctrl at default sizing (64 streams, 2 channels).
module tb_msb_host_req_ctrl;
    localparam int NS  = 64;
    localparam int SW  = 6;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     i_req_v, i_req_r, o_rsp_v, o_rsp_r;
    logic [NCH-1:0]    o_req_v, o_req_r, i_rsp_v, i_rsp_r;
    logic [NCH*SW-1:0] o_req_sid, i_rsp_sid;
    logic              i_rst_v, i_rst_r, o_err;
    logic [SW-1:0]     i_rst_sid;
`ifdef MSB_HOST_REQ_PERF_EN
    logic [31:0]       perf_req, perf_full;
`endif

    int nvec = 0;
    int nerr = 0;
    int g, c0, c1;

    always #5 clk = ~clk;

    msb_host_req_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (i_req_v),
        .i_req_r   (i_req_r),
        .o_req_v   (o_req_v),
        .o_req_r   (o_req_r),
        .o_req_sid (o_req_sid),
        .i_rsp_v   (i_rsp_v),
        .i_rsp_r   (i_rsp_r),
        .i_rsp_sid (i_rsp_sid),
        .o_rsp_v   (o_rsp_v),
        .o_rsp_r   (o_rsp_r),
        .i_rst_v   (i_rst_v),
        .i_rst_r   (i_rst_r),
        .i_rst_sid (i_rst_sid),
        .o_err     (o_err)
`ifdef MSB_HOST_REQ_PERF_EN
        ,
        .o_perf_req  (perf_req),
        .o_perf_full (perf_full)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req_v   = '0;
        o_req_r   = '0;
        i_rsp_v   = '0;
        i_rsp_sid = '0;
        o_rsp_r   = '0;
        i_rst_v   = 1'b0;
        i_rst_sid = '0;
        reset     = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset i_req_r", i_req_r, 64'h0);
        chk("reset o_req_v", 64'(o_req_v), 64'h0);
        chk("reset o_req_sid", 64'(o_req_sid), 64'h0);
        chk("reset i_rsp_r", 64'(i_rsp_r), 64'h0);
        chk("reset o_rsp_v", o_rsp_v, 64'h0);
        chk("reset i_rst_r", 64'(i_rst_r), 64'h0);
        chk("reset o_err", 64'(o_err), 64'h0);

        // single stream saturates at max_out on channel 0
        i_req_v[5] = 1'b1;
        o_req_r    = 2'b11;
        g = 0; c0 = 0; c1 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (i_req_r[5]) g++;
            tick();
            if (o_req_v[0] && (o_req_sid[SW-1:0] == 6'd5)) c0++;
            if (o_req_v[1]) c1++;
        end
        #1;
        chk("single grants", 64'(g), 64'd4);
        chk("single ch0 valid", 64'(c0), 64'd4);
        chk("single ch1 unused", 64'(c1), 64'd0);
        chk("single stalled", i_req_r, 64'h0);
        chk("single cnt5", 64'(dut.cnt_q[5]), 64'd4);

        do_reset();
        chk("midop reset cnt5", 64'(dut.cnt_q[5]), 64'd0);
        chk("midop reset slots", 64'(o_req_v), 64'h0);

        // round-robin fills both slots, third stream waits for a drain
        i_req_v[2:0] = 3'b111;
        #1; chk("rr grant0", i_req_r, 64'h1);
        tick();
        #1; chk("rr grant1", i_req_r, 64'h2);
        tick();
        #1; chk("rr full stall", i_req_r, 64'h0);
        chk("rr slots", 64'(o_req_v), 64'h3);
        chk("rr sids", 64'(o_req_sid), 64'h040);
        tick();
        #1; chk("rr hold sids", 64'(o_req_sid), 64'h040);
        o_req_r = 2'b01;
        #1; chk("rr grant2 on drain", i_req_r, 64'h4);
        tick();
        o_req_r = 2'b00;
        chk("rr slot0 sid2", 64'(o_req_sid), 64'h042);

        // response routing for two channels in the same cycle
        do_reset();
        i_req_v[3] = 1'b1;
        i_req_v[7] = 1'b1;
        o_req_r    = 2'b11;
        #1; chk("route grant3", i_req_r, 64'h8);
        tick();
        #1; chk("route grant7", i_req_r, 64'h80);
        tick();
        i_req_v = '0;
        chk("route cnt3 pre", 64'(dut.cnt_q[3]), 64'd1);
        chk("route cnt7 pre", 64'(dut.cnt_q[7]), 64'd1);
        i_rsp_sid = {6'd7, 6'd3};
        i_rsp_v   = 2'b11;
        o_rsp_r   = '1;
        #1; chk("route acc ch0", 64'(i_rsp_r), 64'h1);
        tick();
        i_rsp_v = 2'b10;
        chk("route o_rsp_v3", o_rsp_v, 64'h8);
        #1; chk("route acc ch1", 64'(i_rsp_r), 64'h2);
        tick();
        i_rsp_v = '0;
        chk("route o_rsp_v7", o_rsp_v, 64'h80);
        chk("route cnt3", 64'(dut.cnt_q[3]), 64'd0);
        chk("route cnt7", 64'(dut.cnt_q[7]), 64'd0);
        chk("route no err", 64'(o_err), 64'h0);
        tick();
        chk("route rsp empty", o_rsp_v, 64'h0);

        // simultaneous grant and response on stream 9
        do_reset();
        i_req_v[9] = 1'b1;
        o_req_r    = 2'b11;
        tick();
        tick();
        chk("sim cnt9 pre", 64'(dut.cnt_q[9]), 64'd2);
        i_rsp_v   = 2'b01;
        i_rsp_sid = {6'd0, 6'd9};
        o_rsp_r   = '1;
        #1;
        chk("sim grant9", i_req_r, 64'(1) << 9);
        chk("sim rsp acc", 64'(i_rsp_r), 64'h1);
        tick();
        i_req_v = '0;
        i_rsp_v = '0;
        chk("sim cnt9 held", 64'(dut.cnt_q[9]), 64'd2);

        // stream reset on 4 with two outstanding refills
        do_reset();
        i_req_v[4] = 1'b1;
        o_req_r    = 2'b11;
        o_rsp_r    = '1;
        tick();
        tick();
        i_req_v = '0;
        chk("srst cnt4 pre", 64'(dut.cnt_q[4]), 64'd2);
        i_rst_v   = 1'b1;
        i_rst_sid = 6'd4;
        #1; chk("srst req cycle", 64'(i_rst_r), 64'h0);
        tick();
        i_req_v[4] = 1'b1;
        i_rst_sid  = 6'd20;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("srst no grant", i_req_r, 64'h0);
            chk("srst wait", 64'(i_rst_r), 64'h0);
            tick();
        end
        i_rsp_v   = 2'b01;
        i_rsp_sid = {6'd0, 6'd4};
        #1; chk("srst rsp1 acc", 64'(i_rsp_r), 64'h1);
        tick();
        i_rsp_v = '0;
        chk("srst cnt4 one", 64'(dut.cnt_q[4]), 64'd1);
        #1; chk("srst wait rsp1", 64'(i_rst_r), 64'h0);
        tick();
        i_rsp_v = 2'b01;
        tick();
        i_rsp_v = '0;
        chk("srst cnt4 zero", 64'(dut.cnt_q[4]), 64'd0);
        chk("srst rsp reg busy", 64'(i_rst_r), 64'h0);
        tick();
        chk("srst drain->done", 64'(i_rst_r), 64'h0);
        tick();
        chk("srst ack", 64'(i_rst_r), 64'h1);
        chk("srst done no grant", i_req_r, 64'h0);
        tick();
        i_rst_v = 1'b0;
        #1;
        chk("srst ack one cycle", 64'(i_rst_r), 64'h0);
        chk("srst stream reopened", i_req_r, 64'(1) << 4);

        // minimum turnaround on an idle stream
        do_reset();
        i_rst_v   = 1'b1;
        i_rst_sid = 6'd20;
        #1; chk("turn N", 64'(i_rst_r), 64'h0);
        tick();
        chk("turn N+1", 64'(i_rst_r), 64'h0);
        tick();
        chk("turn N+2", 64'(i_rst_r), 64'h1);
        tick();
        i_rst_v = 1'b0;
        #1; chk("turn N+3", 64'(i_rst_r), 64'h0);

        // spurious response with zero outstanding
        do_reset();
        i_rsp_v   = 2'b10;
        i_rsp_sid = {6'd11, 6'd0};
        #1; chk("spur acc ch1", 64'(i_rsp_r), 64'h2);
        tick();
        i_rsp_v = '0;
        chk("spur delivered", o_rsp_v, 64'(1) << 11);
        chk("spur err", 64'(o_err), 64'h1);
        chk("spur cnt11", 64'(dut.cnt_q[11]), 64'd0);
        tick();
        chk("spur hold", o_rsp_v, 64'(1) << 11);
        o_rsp_r[11] = 1'b1;
        tick();
        chk("spur drained", o_rsp_v, 64'h0);
        chk("spur err sticky", 64'(o_err), 64'h1);
        do_reset();
        chk("spur err cleared", 64'(o_err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
